// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisor table for a
// 50 MHz clock with 16x oversampling, plus encodings.
package uart_pkg;

  localparam int BAUD_SEL_W  = 3;
  localparam int OSR_DEFAULT = 16;

  localparam logic [BAUD_SEL_W-1:0] BAUD_300    = 3'd0;
  localparam logic [BAUD_SEL_W-1:0] BAUD_1200   = 3'd1;
  localparam logic [BAUD_SEL_W-1:0] BAUD_4800   = 3'd2;
  localparam logic [BAUD_SEL_W-1:0] BAUD_9600   = 3'd3;
  localparam logic [BAUD_SEL_W-1:0] BAUD_19200  = 3'd4;
  localparam logic [BAUD_SEL_W-1:0] BAUD_38400  = 3'd5;
  localparam logic [BAUD_SEL_W-1:0] BAUD_57600  = 3'd6;
  localparam logic [BAUD_SEL_W-1:0] BAUD_115200 = 3'd7;

  localparam logic [15:0] BAUD_DIV_INT [8] = '{
    16'd10416, 16'd2604, 16'd651, 16'd325,
    16'd162,   16'd81,   16'd54,  16'd27
  };

  localparam logic [3:0] BAUD_DIV_FRAC [8] = '{
    4'd11, 4'd3, 4'd1, 4'd8,
    4'd12, 4'd6, 4'd4, 4'd2
  };

endpackage

// File: rtl/uart_frac_div.sv
// Fractional prescaler: D clocks per tick, D+1 when the
// fraction accumulator carries.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  logic              run;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] acc;
  logic [DIV_W-1:0]  eff_int;
  logic [FRAC_W-1:0] eff_frac;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W:0]    cnt_nxt;
  logic [DIV_W:0]    period;
  logic              wrap;

  // The first period after a clear takes the divisor straight
  // from the input; later periods use the latched copy.
  always_comb begin
    eff_int  = run ? act_int : div_int;
    eff_frac = run ? act_frac : div_frac;
    acc_sum  = {1'b0, acc} + {1'b0, eff_frac};
    period   = {1'b0, eff_int}
             + (DIV_W+1)'(acc_sum[FRAC_W]);
    cnt_nxt  = {1'b0, cnt} + (DIV_W+1)'(1);
    wrap     = (cnt_nxt == period);
    tick     = wrap && !clear;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
    end else begin
      run <= 1'b1;
      if (wrap) begin
        cnt <= '0;
        acc <= acc_sum[FRAC_W-1:0];
      end else begin
        cnt <= cnt_nxt[DIV_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_int  <= '0;
      act_frac <= '0;
    end else if (load || clear || !run || wrap) begin
      act_int  <= div_int;
      act_frac <= div_frac;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud tick generator: oversample, mid-bit and bit
// strobes from a table or runtime fractional divisor.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = OSR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BAUD_SEL_W-1:0] baud_select,
  input  logic                  use_cfg,
  input  logic [DIV_W-1:0]      cfg_div_int,
  input  logic [FRAC_W-1:0]     cfg_div_frac,
  input  logic                  resync,
  output logic                  sample_tick,
  output logic                  bit_tick,
  output logic                  mid_tick,
  output logic                  cfg_err
);

  localparam int IDX_W = $clog2(OSR);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(OSR - 1);
  localparam logic [IDX_W-1:0] IDX_MID =
    IDX_W'(OSR / 2 - 1);

  logic [DIV_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic              div_bad;
  logic              hold;
  logic              clear;
  logic              tick;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    sel_int  = DIV_W'(BAUD_DIV_INT[baud_select]);
    sel_frac = FRAC_W'(BAUD_DIV_FRAC[baud_select]);
    if (use_cfg) begin
      sel_int  = cfg_div_int;
      sel_frac = cfg_div_frac;
    end
  end

  assign div_bad = (sel_int < DIV_W'(2));
  assign hold    = resync || !enable;
  assign clear   = hold || div_bad;
  assign cfg_err = div_bad && !reset;

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (hold),
    .div_int  (sel_int),
    .div_frac (sel_frac),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
    end else begin
      sample_tick <= tick;
      bit_tick    <= tick && (idx == IDX_LAST);
      mid_tick    <= tick && (idx == IDX_MID);
      if (clear) begin
        idx <= '0;
      end else if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: table rows plus
// hand sequences, tick times checked through a queue.
module tb_uart_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int FMOD   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [2:0]        baud_select = 3'd7;
  logic              use_cfg = 1'b0;
  logic [DIV_W-1:0]  cfg_div_int = 16'd4;
  logic [FRAC_W-1:0] cfg_div_frac = 4'd0;
  logic              resync = 1'b0;
  logic              sample_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              cfg_err;

  uart_baud_gen #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .OSR    (OSR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .baud_select  (baud_select),
    .use_cfg      (use_cfg),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .resync       (resync),
    .sample_tick  (sample_tick),
    .bit_tick     (bit_tick),
    .mid_tick     (mid_tick),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit bt;
    bit mt;
  } exp_t;

  typedef struct {
    bit       uc;
    logic [2:0] sel;
    int       d;
    int       f;
    int       n;
    int       span;
    int       fmid;
    int       fbit;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_ticks = 0;
  int first_bit = -1;
  int first_mid = -1;
  int last_tick = -1;

  task automatic chk(input string name,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (!sample_tick && (bit_tick || mid_tick))
      chk("strobe_alone", int'(bit_tick | mid_tick), 0);
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_tick", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (sample_tick) begin
      n_ticks++;
      last_tick = cyc;
      if (bit_tick && first_bit < 0) first_bit = cyc;
      if (mid_tick && first_mid < 0) first_mid = cyc;
      if (q.size() == 0) begin
        chk("extra_tick", int'(sample_tick), 0);
      end else begin
        e = q.pop_front();
        chk("tick_cyc", cyc, e.cyc);
        chk("tick_bit", int'(bit_tick), int'(e.bt));
        chk("tick_mid", int'(mid_tick), int'(e.mt));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  // Expected tick edges: D clocks per tick, +1 on carry.
  task automatic push_ticks(input int start, input int d,
                            input int f, input int n,
                            output int last);
    int t;
    int acc;
    exp_t e;
    t = start;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      t += d + (((acc + f) >= FMOD) ? 1 : 0);
      acc = (acc + f) % FMOD;
      e.cyc = t;
      e.bt = ((k % OSR) == OSR - 1);
      e.mt = ((k % OSR) == OSR / 2 - 1);
      q.push_back(e);
    end
    last = t;
  endtask

  task automatic setup(input bit uc, input logic [2:0] sel,
                       input int d, input int f);
    enable = 1'b0;
    resync = 1'b0;
    use_cfg = uc;
    baud_select = sel;
    cfg_div_int = DIV_W'(d);
    cfg_div_frac = FRAC_W'(f);
    step();
    step();
    first_bit = -1;
    first_mid = -1;
    last_tick = -1;
  endtask

  task automatic drain(input int last);
    while (cyc < last) step();
    enable = 1'b0;
    step();
    step();
    chk("queue_empty", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rf;
    int last;
    int n0;
    int low;

    vecs[0] = '{1'b0, 3'd7, 27, 2, 256, 6944, 217, 434};
    vecs[1] = '{1'b1, 3'd0, 4, 0, 32, 128, 32, 64};
    vecs[2] = '{1'b1, 3'd0, 3, 8, 32, 112, 28, 56};
    vecs[3] = '{1'b1, 3'd0, 2, 0, 16, 32, 16, 32};
    vecs[4] = '{1'b0, 3'd5, 81, 6, 16, 1302, 651, 1302};
    vecs[5] = '{1'b0, 3'd6, 54, 4, 16, 868, 434, 868};

    #2;
    chk("rst_sample", int'(sample_tick), 0);
    chk("rst_bit", int'(bit_tick), 0);
    chk("rst_mid", int'(mid_tick), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_sample", int'(sample_tick), 0);

    for (int i = 0; i < 6; i++) begin
      setup(vecs[i].uc, vecs[i].sel, vecs[i].d, vecs[i].f);
      chk("row_cfg_err", int'(cfg_err), 0);
      rf = cyc;
      enable = 1'b1;
      push_ticks(rf, vecs[i].d, vecs[i].f, vecs[i].n, last);
      drain(last);
      chk("row_span", last_tick - rf, vecs[i].span);
      chk("row_first_mid", first_mid - rf, vecs[i].fmid);
      chk("row_first_bit", first_bit - rf, vecs[i].fbit);
    end

    // Divisor switch mid-period keeps the running period.
    setup(1'b1, 3'd0, 3, 8);
    rf = cyc;
    enable = 1'b1;
    q.push_back('{cyc: rf + 3, bt: 1'b0, mt: 1'b0});
    q.push_back('{cyc: rf + 7, bt: 1'b0, mt: 1'b0});
    q.push_back('{cyc: rf + 13, bt: 1'b0, mt: 1'b0});
    q.push_back('{cyc: rf + 19, bt: 1'b0, mt: 1'b0});
    while (cyc < rf + 3) step();
    cfg_div_int = 16'd6;
    cfg_div_frac = 4'd0;
    drain(rf + 19);

    // Resync on the edge of the 10th tick.
    setup(1'b1, 3'd0, 4, 0);
    rf = cyc;
    enable = 1'b1;
    push_ticks(rf, 4, 0, 9, last);
    while (cyc < rf + 39) step();
    resync = 1'b1;
    step();
    chk("resync_no_tick", int'(sample_tick), 0);
    chk("resync_queue", q.size(), 0);
    resync = 1'b0;
    rf = cyc;
    first_bit = -1;
    push_ticks(rf, 4, 0, 16, last);
    drain(last);
    chk("resync_bit", first_bit - rf, 64);

    // Resync held high: no ticks.
    setup(1'b1, 3'd0, 4, 0);
    enable = 1'b1;
    resync = 1'b1;
    n0 = n_ticks;
    repeat (20) step();
    chk("resync_hold", n_ticks - n0, 0);
    resync = 1'b0;
    enable = 1'b0;
    step();

    // D=1 is illegal, D=2 is the smallest legal divisor.
    setup(1'b1, 3'd0, 1, 0);
    chk("cfg_err_set", int'(cfg_err), 1);
    enable = 1'b1;
    n0 = n_ticks;
    low = 0;
    repeat (100) begin
      step();
      if (!cfg_err) low++;
    end
    chk("cfg_err_hold", low, 0);
    chk("cfg_err_ticks", n_ticks - n0, 0);
    cfg_div_int = 16'd2;
    #1;
    chk("cfg_err_clear", int'(cfg_err), 0);
    rf = cyc;
    push_ticks(rf, 2, 0, 8, last);
    drain(last);

    // Async reset between edges, right after the mid tick.
    setup(1'b1, 3'd0, 4, 0);
    rf = cyc;
    enable = 1'b1;
    push_ticks(rf, 4, 0, 8, last);
    while (cyc < rf + 32) step();
    chk("pre_rst_mid", int'(mid_tick), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sample", int'(sample_tick), 0);
    chk("arst_mid", int'(mid_tick), 0);
    chk("arst_bit", int'(bit_tick), 0);
    chk("arst_queue", q.size(), 0);
    step();
    #2;
    reset = 1'b0;
    rf = cyc;
    push_ticks(rf, 4, 0, 16, last);
    drain(last);

    // Enable low for a single clock after the mid tick.
    setup(1'b1, 3'd0, 4, 0);
    rf = cyc;
    enable = 1'b1;
    push_ticks(rf, 4, 0, 8, last);
    while (cyc < rf + 33) step();
    enable = 1'b0;
    step();
    chk("en_low_out",
        int'(sample_tick | mid_tick | bit_tick), 0);
    enable = 1'b1;
    rf = cyc;
    push_ticks(rf, 4, 0, 16, last);
    drain(last);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
